spi_master_scheduler: RTL and testbench

SPI_MASTER_SCHEDULER -- requirements
Module: spi_master_scheduler

---
 rtl/spi_sched_pkg.sv | 20 ++
 rtl/spi_master_scheduler_if.sv | 35 +++
 rtl/spi_master_scheduler_rr_arbiter.sv | 37 +++
 rtl/spi_master_scheduler.sv | 156 +++++++++++++++
 tb/tb_spi_master_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_sched_pkg.sv
// Shared definitions for the SPI master scheduler: FSM encoding and field widths.
package spi_sched_pkg;

  // Width of the per-transaction byte counter; 9 bits so that 256 never wraps.
  localparam int LEN_W  = 9;
  // SPI mode field {CPOL, CPHA}.
  localparam int MODE_W = 2;
  // Width of the setup/hold/gap phase counter.
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SETUP      = 3'd1,
    S_XFER_START = 3'd2,
    S_XFER_WAIT  = 3'd3,
    S_HOLD       = 3'd4,
    S_GAP        = 3'd5
  } state_e;

endpackage

// File: rtl/spi_master_scheduler_if.sv
// Requester/engine bundle of the SPI master scheduler.
//
// Handshake: a requester raises i_req[k] (a level, not a pulse) with i_len/i_mode
// valid and keeps it high until it sees o_txn_done[k]; dropping it early asks
// the scheduler to finish the byte in flight and close the transaction.
// The shared engine is told to send one byte by a single-cycle o_start and
// reports completion with a single-cycle i_byte_done; each completed byte is
// reflected back to the owner as a single-cycle o_byte_ack.
interface spi_master_scheduler_if
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        i_req;
  logic [8*NUM_REQ-1:0]      i_len;
  logic [MODE_W*NUM_REQ-1:0] i_mode;
  logic                      i_byte_done;
  logic [NUM_REQ-1:0]        o_grant;
  logic [NUM_REQ-1:0]        o_SS_n;
  logic                      o_start;
  logic [MODE_W-1:0]         o_mode;
  logic [NUM_REQ-1:0]        o_byte_ack;
  logic [NUM_REQ-1:0]        o_txn_done;
  logic                      o_busy;

  modport master (
    output i_req, i_len, i_mode, i_byte_done,
    input  o_grant, o_SS_n, o_start, o_mode, o_byte_ack, o_txn_done, o_busy
  );

  modport slave (
    input  i_req, i_len, i_mode, i_byte_done,
    output o_grant, o_SS_n, o_start, o_mode, o_byte_ack, o_txn_done, o_busy
  );
endinterface

// File: rtl/spi_master_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the requester closest after i_last wins.
module rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant
);

  int w_dist;
  int w_best_dist;
  int w_best_k;

  // Rank each requester by its distance after the last winner; lowest wins.
  always_comb begin
    w_dist      = 0;
    w_best_dist = NUM_REQ;
    w_best_k    = 0;
    o_grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_dist = (k + NUM_REQ - 1 - int'(i_last)) % NUM_REQ;
      if (i_req[k] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_k    = k;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if ((w_best_dist < NUM_REQ) && (k == w_best_k)) begin
        o_grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_scheduler.sv
// SPI master scheduler: arbitrates requesters onto one shared SPI byte engine,
// framing each transaction with slave-select setup, hold and idle gap.
// SETUP_CYC, HOLD_CYC and GAP_CYC are meaningful from 1 upwards; 0 acts as 1.
module spi_master_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  spi_master_scheduler_if.slave  bus,
  output state_e                 o_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_ss_n;
  logic [NUM_REQ-1:0]   r_byte_ack;
  logic [NUM_REQ-1:0]   r_txn_done;
  logic                 r_start;
  logic [MODE_W-1:0]    r_mode;
  logic [LEN_W-1:0]     r_rem;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_last;

  logic [NUM_REQ-1:0]   w_arb_grant;
  logic [IDX_W-1:0]     w_win_idx;
  logic [LEN_W-1:0]     w_win_len;
  logic [MODE_W-1:0]    w_win_mode;
  logic                 w_owner_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req   (bus.i_req),
    .i_last  (r_last),
    .o_grant (w_arb_grant)
  );

  // Pick out the winner's index, length (0 means 1) and mode.
  always_comb begin
    w_win_idx  = '0;
    w_win_len  = '0;
    w_win_mode = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_arb_grant[k]) begin
        w_win_idx  = IDX_W'(k);
        w_win_len  = (bus.i_len[8*k +: 8] == 8'd0) ? LEN_W'(1) : LEN_W'(bus.i_len[8*k +: 8]);
        w_win_mode = bus.i_mode[MODE_W*k +: MODE_W];
      end
    end
  end

  assign w_owner_req = |(bus.i_req & r_grant);

  // Transaction FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_ss_n     <= '1;
      r_byte_ack <= '0;
      r_txn_done <= '0;
      r_start    <= 1'b0;
      r_mode     <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_last     <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_start    <= 1'b0;
      r_byte_ack <= '0;
      r_txn_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|bus.i_req) begin
            r_grant <= w_arb_grant;
            r_ss_n  <= ~w_arb_grant;
            r_rem   <= w_win_len;
            r_mode  <= w_win_mode;
            r_last  <= w_win_idx;
            r_cnt   <= '0;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (!w_owner_req) begin
            r_cnt   <= '0;
            r_state <= S_HOLD;
          end else if (int'(r_cnt) + 1 >= SETUP_CYC) begin
            r_cnt   <= '0;
            r_start <= 1'b1;
            r_state <= S_XFER_START;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_XFER_START: begin
          r_state <= S_XFER_WAIT;
        end
        S_XFER_WAIT: begin
          // A dropped request still lets the byte in flight finish.
          if (bus.i_byte_done) begin
            r_byte_ack <= r_grant;
            r_rem      <= r_rem - 1'b1;
            if ((r_rem <= LEN_W'(1)) || !w_owner_req) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_start <= 1'b1;
              r_state <= S_XFER_START;
            end
          end
        end
        S_HOLD: begin
          if (int'(r_cnt) + 1 >= HOLD_CYC) begin
            r_cnt      <= '0;
            r_ss_n     <= '1;
            r_txn_done <= r_grant;
            r_grant    <= '0;
            r_mode     <= '0;
            r_state    <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (int'(r_cnt) + 1 >= GAP_CYC) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_grant    = r_grant;
  assign bus.o_SS_n     = r_ss_n;
  assign bus.o_start    = r_start;
  assign bus.o_mode     = r_mode;
  assign bus.o_byte_ack = r_byte_ack;
  assign bus.o_txn_done = r_txn_done;
  assign bus.o_busy     = (r_state != S_IDLE);
  assign o_state        = r_state;

endmodule

// File: tb/tb_spi_master_scheduler.sv
// Bench for spi_master_scheduler: directed transactions, expected events queued
// at stimulus time and checked by an independent negedge monitor.
module tb_spi_master_scheduler;
  import spi_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int GAP_CYC = 1;
  localparam logic [1:0] EV_GRANT = 2'd0;
  localparam logic [1:0] EV_START = 2'd1;
  localparam logic [1:0] EV_ACK   = 2'd2;
  localparam logic [1:0] EV_DONE  = 2'd3;
  localparam logic [NUM_REQ-1:0] ONES = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  state_e dbg_state;
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int last_done_cyc = 0;
  logic have_done = 1'b0;
  logic chk_gap = 1'b0;
  logic [NUM_REQ-1:0] prev_grant = '0;

  spi_master_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();

  spi_master_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .SETUP_CYC (2),
    .HOLD_CYC  (2),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [3:0] oh2idx(input logic [NUM_REQ-1:0] v);
    logic [3:0] r;
    int n;
    r = 4'hF;
    n = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[k]) begin
        r = 4'(k);
        n++;
      end
    end
    if (n != 1) r = 4'hF;
    return r;
  endfunction

  function automatic logic [7:0] mk(input logic [1:0] t, input logic [1:0] m, input int idx);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {t, m, i4};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_evt(input string name, input logic [7:0] got);
    logic [7:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: got event %h expected none", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        tests_failed++;
        $display("FAIL %s: got event %h expected %h", name, got, e);
      end
    end
  endtask

  // Queue one full transaction: grant, nbytes of start/ack, done.
  task automatic exp_txn(input int idx, input logic [1:0] mode, input int nbytes);
    exp_q.push_back(mk(EV_GRANT, mode, idx));
    for (int b = 0; b < nbytes; b++) begin
      exp_q.push_back(mk(EV_START, mode, idx));
      exp_q.push_back(mk(EV_ACK, 2'd0, idx));
    end
    exp_q.push_back(mk(EV_DONE, 2'd0, idx));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] inv_grant;
    if (rst_n) begin
      cyc++;
      inv_grant = ~bus.o_grant;
      check("ss_matches_grant", bus.o_SS_n, inv_grant);
      if ((bus.o_grant != '0) && (prev_grant == '0)) begin
        check_evt("grant", mk(EV_GRANT, bus.o_mode, int'(oh2idx(bus.o_grant))));
        if (chk_gap && have_done) check("gap_len", cyc - last_done_cyc, GAP_CYC + 1);
      end
      if (bus.o_byte_ack != '0) check_evt("ack", mk(EV_ACK, 2'd0, int'(oh2idx(bus.o_byte_ack))));
      if (bus.o_start) check_evt("start", mk(EV_START, bus.o_mode, int'(oh2idx(bus.o_grant))));
      if (bus.o_txn_done != '0) begin
        check_evt("done", mk(EV_DONE, 2'd0, int'(oh2idx(bus.o_txn_done))));
        check("ss_at_done", bus.o_SS_n, ONES);
        have_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    prev_grant = bus.o_grant;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start();
    int n = 0;
    while (!bus.o_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wait_start", bus.o_start, 1);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (bus.o_grant == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wait_grant", (bus.o_grant != '0), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.o_txn_done == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", (bus.o_txn_done != '0), 1);
  endtask

  // Engine model: finish a byte 4 cycles after its start, optionally dropping requests.
  task automatic engine_byte(input logic [NUM_REQ-1:0] drop_mask);
    wait_start();
    repeat (3) @(negedge clk);
    bus.i_byte_done = 1'b1;
    bus.i_req = bus.i_req & ~drop_mask;
    @(negedge clk);
    bus.i_byte_done = 1'b0;
  endtask

  task automatic stray_done();
    bus.i_byte_done = 1'b1;
    @(negedge clk);
    bus.i_byte_done = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.i_req = '0;
    bus.i_len = '0;
    bus.i_mode = '0;
    bus.i_byte_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_grant", bus.o_grant, 0);
    check("rst_ss", bus.o_SS_n, ONES);
    check("rst_start", bus.o_start, 0);
    check("rst_mode", bus.o_mode, 0);
    check("rst_ack", bus.o_byte_ack, 0);
    check("rst_done", bus.o_txn_done, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin with all four requesting, one byte each: 0,1,2,3,0.
    bus.i_len = {4{8'h01}};
    bus.i_mode = 8'b11_10_01_00;
    exp_txn(0, 2'd0, 1);
    exp_txn(1, 2'd1, 1);
    exp_txn(2, 2'd2, 1);
    exp_txn(3, 2'd3, 1);
    exp_txn(0, 2'd0, 1);
    have_done = 1'b0;
    chk_gap = 1'b1;
    bus.i_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      engine_byte('0);
      wait_done();
    end
    bus.i_req = '0;
    chk_gap = 1'b0;
    drain("rr_drained");

    // Three bytes on requester 0; len/mode changes after grant are ignored.
    bus.i_len[7:0] = 8'd3;
    bus.i_mode[1:0] = 2'b11;
    exp_txn(0, 2'b11, 3);
    bus.i_req = 4'b0001;
    wait_grant();
    bus.i_len[7:0] = 8'd9;
    bus.i_mode[1:0] = 2'b00;
    for (int i = 0; i < 3; i++) engine_byte('0);
    wait_done();
    bus.i_req = '0;
    drain("len3_drained");

    // Length zero behaves as one byte.
    bus.i_len[23:16] = 8'd0;
    bus.i_mode[5:4] = 2'b10;
    exp_txn(2, 2'b10, 1);
    bus.i_req = 4'b0100;
    engine_byte('0);
    wait_done();
    bus.i_req = '0;
    drain("len0_drained");

    // Length 5, request dropped together with the second byte_done.
    bus.i_len[15:8] = 8'd5;
    bus.i_mode[3:2] = 2'b01;
    exp_txn(1, 2'b01, 2);
    bus.i_req = 4'b0010;
    engine_byte('0);
    engine_byte(4'b0010);
    wait_done();
    drain("drop_drained");

    // Request dropped during SETUP: straight to HOLD, no byte started.
    bus.i_len[23:16] = 8'd3;
    exp_txn(2, 2'b10, 0);
    bus.i_req = 4'b0100;
    wait_grant();
    bus.i_req = '0;
    wait_done();
    drain("setup_drop_drained");

    // Stray byte_done in SETUP and in GAP is ignored.
    bus.i_len[31:24] = 8'd2;
    bus.i_mode[7:6] = 2'b11;
    exp_txn(3, 2'b11, 2);
    bus.i_req = 4'b1000;
    wait_grant();
    stray_done();
    engine_byte('0);
    engine_byte('0);
    wait_done();
    bus.i_req = '0;
    stray_done();
    drain("stray_drained");

    // Reset during XFER_WAIT aborts silently; arbitration restarts at index 0.
    bus.i_len[15:8] = 8'd4;
    exp_q.push_back(mk(EV_GRANT, 2'b01, 1));
    exp_q.push_back(mk(EV_START, 2'b01, 1));
    bus.i_req = 4'b0010;
    wait_start();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_grant", bus.o_grant, 0);
    check("arst_ss", bus.o_SS_n, ONES);
    check("arst_start", bus.o_start, 0);
    check("arst_done", bus.o_txn_done, 0);
    check("arst_busy", bus.o_busy, 0);
    check("arst_mode", bus.o_mode, 0);
    bus.i_req = '0;
    bus.i_len = {4{8'h01}};
    bus.i_mode[1:0] = 2'b10;
    repeat (2) @(negedge clk);
    check("arst_queue", exp_q.size(), 0);
    exp_txn(0, 2'b10, 1);
    bus.i_req = 4'b1111;
    rst_n = 1'b1;
    wait_grant();
    bus.i_req = 4'b0001;
    engine_byte('0);
    wait_done();
    bus.i_req = '0;
    drain("post_reset_drained");

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
